// File: rtl/instr_encoder_pkg.sv
// Shared types and constants for the instruction encoder.
//   enc_fmt_t     : descriptor format code carried on in_fmt
//   enc_desc_t    : registered descriptor (stage 1 contents)
//   OPCODE_*      : 3-bit major opcodes placed in word[31:29]
//   FUNCT3_*      : minor opcodes for the memory and branch groups
//   IMM_W_*       : signed immediate field widths checked when range checking is enabled
//   FUNCT4_*_MAX  : highest defined function code per format
package instr_encoder_pkg;

  typedef enum logic [3:0] {
    FmtR    = 4'd0,
    FmtI    = 4'd1,
    FmtF    = 4'd2,
    FmtLw   = 4'd3,
    FmtSw   = 4'd4,
    FmtFlw  = 4'd5,
    FmtFsw  = 4'd6,
    FmtUp   = 4'd7,
    FmtJal  = 4'd8,
    FmtBeqz = 4'd9,
    FmtHalt = 4'd10
  } enc_fmt_t;

  typedef enum logic [1:0] {StIdle, StRun, StDone} enc_state_t;

  typedef struct packed {
    logic [3:0]  fmt;
    logic [3:0]  funct4;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic        scalar;
  } enc_desc_t;

  localparam logic [2:0] OPCODE_R    = 3'd0;
  localparam logic [2:0] OPCODE_I    = 3'd1;
  localparam logic [2:0] OPCODE_F    = 3'd2;
  localparam logic [2:0] OPCODE_MEM  = 3'd3;
  localparam logic [2:0] OPCODE_UP   = 3'd4;
  localparam logic [2:0] OPCODE_BR   = 3'd5;
  localparam logic [2:0] OPCODE_HALT = 3'd7;

  localparam logic [2:0] FUNCT3_LW   = 3'b000;
  localparam logic [2:0] FUNCT3_SW   = 3'b001;
  localparam logic [2:0] FUNCT3_FLW  = 3'b010;
  localparam logic [2:0] FUNCT3_FSW  = 3'b011;
  localparam logic [2:0] FUNCT3_JAL  = 3'b000;
  localparam logic [2:0] FUNCT3_BEQZ = 3'b001;

  localparam int IMM_W_I   = 14;
  localparam int IMM_W_MEM = 15;
  localparam int IMM_W_BR  = 18;
  localparam int IMM_W_JAL = 28;

  localparam logic [3:0] FUNCT4_R_MAX = 4'd9;
  localparam logic [3:0] FUNCT4_I_MAX = 4'd8;
  localparam logic [3:0] FUNCT4_F_MAX = 4'd5;

  // True when imm is representable as a width-bit two's complement value.
  function automatic logic imm_fits(input logic [31:0] imm, input int width);
    logic signed [31:0] sh;
    sh = $signed(imm) >>> (width - 1);
    return (sh == '0) || (sh == '1);
  endfunction

endpackage

// File: rtl/instr_encoder_pack.sv
// Combinational descriptor-to-word packer.
//   fmt_i/funct4_i/rd_i/rs1_i/rs2_i/imm_i/scalar_i : descriptor fields
//   word_o   : packed 32-bit instruction (fields ORed together, unused bits 0)
//   reject_o : descriptor cannot be encoded; word_o must not be written
// Build option INSTR_ENCODER_RANGE_CHECK_EN adds immediate range/alignment and
// function-code checks; without it only an undefined format is rejected.
module instr_pack
  import instr_encoder_pkg::*;
(
  input  logic [3:0]  fmt_i,
  input  logic [3:0]  funct4_i,
  input  logic [4:0]  rd_i,
  input  logic [4:0]  rs1_i,
  input  logic [4:0]  rs2_i,
  input  logic [31:0] imm_i,
  input  logic        scalar_i,
  output logic [31:0] word_o,
  output logic        reject_o
);

  logic fmt_bad;
  logic range_bad;

  always_comb begin
    word_o  = '0;
    fmt_bad = 1'b0;
    case (fmt_i)
      FmtR: word_o = {OPCODE_R, 29'd0} | 32'(rd_i) | (32'(rs1_i) << 5) | (32'(funct4_i) << 10)
                   | (32'(rs2_i) << 14) | (32'(scalar_i) << 28);
      FmtI: word_o = {OPCODE_I, 29'd0} | 32'(rd_i) | (32'(rs1_i) << 5) | (32'(funct4_i) << 10)
                   | (32'(imm_i[13:0]) << 14) | (32'(scalar_i) << 28);
      FmtF: word_o = {OPCODE_F, 29'd0} | 32'(rd_i) | (32'(rs1_i) << 5) | (32'(funct4_i) << 10)
                   | (32'(scalar_i) << 28);
      FmtLw, FmtFlw: word_o = {OPCODE_MEM, 29'd0}
                   | (32'((fmt_i == FmtFlw) ? FUNCT3_FLW : FUNCT3_LW) << 12)
                   | 32'(rd_i) | (32'(rs1_i) << 5) | (32'(imm_i[14:0]) << 14)
                   | (32'(scalar_i) << 13);
      FmtSw, FmtFsw: word_o = {OPCODE_MEM, 29'd0}
                   | (32'((fmt_i == FmtFsw) ? FUNCT3_FSW : FUNCT3_SW) << 12)
                   | (32'(rs1_i) << 5) | (32'(rs2_i) << 14) | (32'(imm_i[14:5]) << 19)
                   | 32'(imm_i[4:0]) | (32'(scalar_i) << 13);
      FmtUp: word_o = {OPCODE_UP, 29'd0} | 32'(rd_i) | (32'(imm_i[31:12]) << 9)
                   | (32'(scalar_i) << 5);
      FmtJal: word_o = {OPCODE_BR, 29'd0} | (32'(FUNCT3_JAL) << 12)
                   | (32'(imm_i[27:12]) << 13) | 32'(imm_i[11:2]);
      FmtBeqz: word_o = {OPCODE_BR, 29'd0} | (32'(FUNCT3_BEQZ) << 12) | (32'(rs1_i) << 5)
                   | (32'(rs2_i) << 14) | (32'(imm_i[17:8]) << 19) | (32'(imm_i[7]) << 13)
                   | 32'(imm_i[6:2]);
      FmtHalt: word_o = {OPCODE_HALT, 29'd0};
      default: fmt_bad = 1'b1;
    endcase
  end

`ifdef INSTR_ENCODER_RANGE_CHECK_EN
  always_comb begin
    range_bad = 1'b0;
    case (fmt_i)
      FmtR:    range_bad = funct4_i > FUNCT4_R_MAX;
      FmtI:    range_bad = !imm_fits(imm_i, IMM_W_I) || (funct4_i > FUNCT4_I_MAX);
      FmtF:    range_bad = funct4_i > FUNCT4_F_MAX;
      FmtLw, FmtSw, FmtFlw, FmtFsw: range_bad = !imm_fits(imm_i, IMM_W_MEM);
      FmtUp:   range_bad = imm_i[11:0] != 12'd0;
      FmtJal:  range_bad = !imm_fits(imm_i, IMM_W_JAL) || (imm_i[1:0] != 2'b00);
      FmtBeqz: range_bad = !imm_fits(imm_i, IMM_W_BR) || (imm_i[1:0] != 2'b00);
      default: range_bad = 1'b0;
    endcase
  end
`else
  assign range_bad = 1'b0;
`endif

  assign reject_o = fmt_bad | range_bad;

endmodule

// File: rtl/instr_encoder.sv
// Instruction encoder: accepts descriptors, packs them into 32-bit words and
// writes them to consecutive instruction-memory addresses.
//   clk, reset (async, active low)
//   start/base_addr        : begin a program (ignored while running)
//   in_valid/in_ready/in_* : descriptor handshake
//   mem_we/mem_ready/mem_addr/mem_wdata : memory write handshake
//   busy, done (pulse), err (sticky), err_cnt (saturating)
// Pipeline: stage 1 holds the accepted descriptor, stage 2 holds the packed
// word and write strobe. Build option INSTR_ENCODER_RANGE_CHECK_EN enables
// stricter descriptor rejection inside instr_pack.
module instr_encoder
  import instr_encoder_pkg::*;
#(
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [ADDR_W-1:0]    base_addr,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [3:0]           in_fmt,
  input  logic [3:0]           in_funct4,
  input  logic [4:0]           in_rd,
  input  logic [4:0]           in_rs1,
  input  logic [4:0]           in_rs2,
  input  logic [31:0]          in_imm,
  input  logic                 in_scalar,
  output logic                 mem_we,
  input  logic                 mem_ready,
  output logic [ADDR_W-1:0]    mem_addr,
  output logic [31:0]          mem_wdata,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  enc_state_t            state_q, state_d;
  logic                  halt_seen_q, halt_seen_d;
  logic                  s1_valid_q, s1_valid_d;
  enc_desc_t             s1_q, s1_d;
  logic                  mem_we_q, mem_we_d;
  logic [31:0]           mem_wdata_q, mem_wdata_d;
  logic                  s2_halt_q, s2_halt_d;
  logic [ADDR_W-1:0]     mem_addr_q, mem_addr_d;
  logic                  err_q, err_d;
  logic [ERR_CNT_W-1:0]  err_cnt_q, err_cnt_d;
  logic                  done_q, done_d;

  enc_desc_t   in_desc;
  logic [31:0] pack_word;
  logic        pack_reject;
  logic        s2_free, s1_adv, accept, wr_fire, s1_is_halt;

  assign in_desc = '{fmt: in_fmt, funct4: in_funct4, rd: in_rd, rs1: in_rs1, rs2: in_rs2,
                     imm: in_imm, scalar: in_scalar};

  instr_pack u_pack (
    .fmt_i    (s1_q.fmt),
    .funct4_i (s1_q.funct4),
    .rd_i     (s1_q.rd),
    .rs1_i    (s1_q.rs1),
    .rs2_i    (s1_q.rs2),
    .imm_i    (s1_q.imm),
    .scalar_i (s1_q.scalar),
    .word_o   (pack_word),
    .reject_o (pack_reject)
  );

  // Stage 2 can take a new word when empty or when its write completes now.
  assign s2_free    = ~mem_we_q | mem_ready;
  assign s1_adv     = s1_valid_q & s2_free;
  assign in_ready   = (state_q == StRun) & ~halt_seen_q & (~s1_valid_q | s1_adv);
  assign accept     = in_valid & in_ready;
  assign wr_fire    = mem_we_q & mem_ready;
  assign s1_is_halt = (s1_q.fmt == FmtHalt);

  always_comb begin
    state_d     = state_q;
    halt_seen_d = halt_seen_q;
    s1_valid_d  = s1_valid_q;
    s1_d        = s1_q;
    mem_we_d    = mem_we_q;
    mem_wdata_d = mem_wdata_q;
    s2_halt_d   = s2_halt_q;
    mem_addr_d  = mem_addr_q;
    err_d       = err_q;
    err_cnt_d   = err_cnt_q;
    done_d      = 1'b0;

    if (accept) begin
      s1_d       = in_desc;
      s1_valid_d = 1'b1;
      if (in_fmt == FmtHalt) halt_seen_d = 1'b1;
    end else if (s1_adv) begin
      s1_valid_d = 1'b0;
    end

    if (s2_free) begin
      mem_we_d  = s1_adv & ~pack_reject;
      s2_halt_d = s1_adv & ~pack_reject & s1_is_halt;
      if (s1_adv && !pack_reject) mem_wdata_d = pack_word;
    end

    if (s1_adv && pack_reject) begin
      err_d = 1'b1;
      if (err_cnt_q != '1) err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
      // A HALT that cannot be written still terminates the program.
      if (s1_is_halt) begin
        state_d = StDone;
        done_d  = 1'b1;
      end
    end

    if (wr_fire) begin
      mem_addr_d = mem_addr_q + ADDR_W'(1);
      if (s2_halt_q) begin
        state_d = StDone;
        done_d  = 1'b1;
      end
    end

    if (start && state_q != StRun) begin
      state_d     = StRun;
      mem_addr_d  = base_addr;
      err_d       = 1'b0;
      err_cnt_d   = '0;
      halt_seen_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      halt_seen_q <= 1'b0;
      s1_valid_q  <= 1'b0;
      s1_q        <= '0;
      mem_we_q    <= 1'b0;
      mem_wdata_q <= '0;
      s2_halt_q   <= 1'b0;
      mem_addr_q  <= '0;
      err_q       <= 1'b0;
      err_cnt_q   <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      halt_seen_q <= halt_seen_d;
      s1_valid_q  <= s1_valid_d;
      s1_q        <= s1_d;
      mem_we_q    <= mem_we_d;
      mem_wdata_q <= mem_wdata_d;
      s2_halt_q   <= s2_halt_d;
      mem_addr_q  <= mem_addr_d;
      err_q       <= err_d;
      err_cnt_q   <= err_cnt_d;
      done_q      <= done_d;
    end
  end

  assign mem_we    = mem_we_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_addr  = mem_addr_q;
  assign busy      = (state_q != StIdle);
  assign done      = done_q;
  assign err       = err_q;
  assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_instr_encoder.sv
module tb_instr_encoder;
  import instr_encoder_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  base_addr = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  in_fmt = '0;
  logic [3:0]  in_funct4 = '0;
  logic [4:0]  in_rd = '0, in_rs1 = '0, in_rs2 = '0;
  logic [31:0] in_imm = '0;
  logic        in_scalar = 1'b0;
  logic        mem_we;
  logic        mem_ready = 1'b1;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        busy, done, err;
  logic [7:0]  err_cnt;

  int n_checks = 0;
  int n_fail = 0;
  int unsigned cyc = 0;
  logic [7:0]  log_addr[$];
  logic [31:0] log_data[$];
  int unsigned log_cyc[$];

  always #5 clk = ~clk;

  instr_encoder dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .base_addr (base_addr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_fmt    (in_fmt),
    .in_funct4 (in_funct4),
    .in_rd     (in_rd),
    .in_rs1    (in_rs1),
    .in_rs2    (in_rs2),
    .in_imm    (in_imm),
    .in_scalar (in_scalar),
    .mem_we    (mem_we),
    .mem_ready (mem_ready),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .err_cnt   (err_cnt)
  );

  always @(posedge clk) cyc <= cyc + 1;

  // Record every write handshake that the next rising edge will complete.
  always @(negedge clk) begin
    if (reset && mem_we && mem_ready) begin
      log_addr.push_back(mem_addr);
      log_data.push_back(mem_wdata);
      log_cyc.push_back(cyc);
    end
  end

  task automatic clear_log();
    log_addr.delete();
    log_data.delete();
    log_cyc.delete();
  endtask

  task automatic drain(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Present one descriptor and hold it until accepted (bounded).
  task automatic send(input logic [3:0] fmt, input logic [3:0] f4, input logic [4:0] rd,
                      input logic [4:0] rs1, input logic [4:0] rs2, input logic [31:0] imm,
                      input logic sc);
    int n = 0;
    in_valid = 1'b1; in_fmt = fmt; in_funct4 = f4; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
    in_imm = imm; in_scalar = sc;
    #1;
    while (!in_ready && n < 50) begin
      @(posedge clk); #2; n++;
    end
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++; $display("FAIL send_accept: in_ready=%b required 1 (timeout)", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic do_start(input logic [7:0] base);
    start = 1'b1; base_addr = base;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %b need 0", in_ready); end
    n_checks++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL reset_mem_we: got %b need 0", mem_we); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b need 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b need 0", done); end
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b need 0", err); end
    n_checks++; if (mem_addr !== 8'h00) begin n_fail++; $display("FAIL reset_addr: got %h need 00", mem_addr); end
    n_checks++; if (mem_wdata !== 32'h0) begin n_fail++; $display("FAIL reset_wdata: got %h need 0", mem_wdata); end
    n_checks++; if (err_cnt !== 8'h00) begin n_fail++; $display("FAIL reset_err_cnt: got %h need 00", err_cnt); end
    reset = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL idle_busy: got %b need 0", busy); end
  endtask

  task automatic test_start();
    do_start(8'h10);
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL start_busy: got %b need 1", busy); end
    n_checks++; if (mem_addr !== 8'h10) begin n_fail++; $display("FAIL start_addr: got %h need 10", mem_addr); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL start_in_ready: got %b need 1", in_ready); end
  endtask

  task automatic test_single_i();
    logic [31:0] exp;
    exp = {OPCODE_I, 29'h0} | 32'h0FFF_C043;
    clear_log();
    send(FmtI, 4'd0, 5'd3, 5'd2, 5'd0, 32'hFFFF_FFFF, 1'b0);
    n_checks++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL addi_early_we: got %b need 0", mem_we); end
    @(posedge clk); #1;
    n_checks++; if (mem_we !== 1'b1) begin n_fail++; $display("FAIL addi_we: got %b need 1", mem_we); end
    n_checks++; if (mem_addr !== 8'h10) begin n_fail++; $display("FAIL addi_addr: got %h need 10", mem_addr); end
    n_checks++; if (mem_wdata !== exp) begin n_fail++; $display("FAIL addi_wdata: got %h need %h", mem_wdata, exp); end
    @(posedge clk); #1;
    n_checks++; if (mem_addr !== 8'h11) begin n_fail++; $display("FAIL addi_addr_inc: got %h need 11", mem_addr); end
    n_checks++; if (log_addr.size() != 1) begin n_fail++; $display("FAIL addi_writes: got %0d need 1", log_addr.size()); end
  endtask

  task automatic test_back_to_back();
    clear_log();
    for (int i = 0; i < 4; i++) send(FmtR, 4'd2, 5'(i + 1), 5'd5, 5'd7, 32'h0, 1'b1);
    drain(5);
    n_checks++;
    if (log_addr.size() != 4) begin
      n_fail++; $display("FAIL b2b_count: got %0d need 4", log_addr.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_checks++;
        if (log_addr[i] !== 8'(8'h11 + i) || log_data[i] !== (32'h1001_C8A0 | 32'(i + 1))) begin
          n_fail++; $display("FAIL b2b_word%0d: got %h@%h need %h@%h", i, log_data[i], log_addr[i],
                             32'h1001_C8A0 | 32'(i + 1), 8'(8'h11 + i));
        end
        if (i > 0) begin
          n_checks++;
          if (log_cyc[i] != log_cyc[i-1] + 1) begin
            n_fail++; $display("FAIL b2b_gap%0d: got %0d cycles need 1", i, log_cyc[i] - log_cyc[i-1]);
          end
        end
      end
    end
  endtask

  task automatic test_stall();
    clear_log();
    mem_ready = 1'b0;
    send(FmtF, 4'd3, 5'd9, 5'd10, 5'd0, 32'h0, 1'b0);
    send(FmtUp, 4'd0, 5'd1, 5'd0, 5'd0, 32'h1234_5000, 1'b1);
    repeat (3) begin
      #1;
      n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL stall_in_ready: got %b need 0", in_ready); end
      n_checks++; if (mem_we !== 1'b1) begin n_fail++; $display("FAIL stall_we: got %b need 1", mem_we); end
      n_checks++; if (mem_addr !== 8'h15) begin n_fail++; $display("FAIL stall_addr: got %h need 15", mem_addr); end
      n_checks++; if (mem_wdata !== 32'h4000_0D49) begin n_fail++; $display("FAIL stall_wdata: got %h need 40000d49", mem_wdata); end
      @(posedge clk); #1;
    end
    mem_ready = 1'b1;
    drain(5);
    n_checks++;
    if (log_addr.size() != 2) begin
      n_fail++; $display("FAIL stall_count: got %0d need 2", log_addr.size());
    end else begin
      n_checks++;
      if (log_addr[0] !== 8'h15 || log_data[0] !== 32'h4000_0D49) begin
        n_fail++; $display("FAIL stall_word0: got %h@%h need 40000d49@15", log_data[0], log_addr[0]);
      end
      n_checks++;
      if (log_addr[1] !== 8'h16 || log_data[1] !== 32'h8246_8A21) begin
        n_fail++; $display("FAIL stall_word1: got %h@%h need 82468a21@16", log_data[1], log_addr[1]);
      end
    end
  endtask

  task automatic test_formats();
    logic [31:0] exp[3];
    exp[0] = 32'h6008_F045; exp[1] = 32'hA000_2002; exp[2] = 32'hA008_B021;
    clear_log();
    send(FmtSw, 4'd0, 5'd0, 5'd2, 5'd3, 32'h25, 1'b1);
    send(FmtJal, 4'd0, 5'd0, 5'd0, 5'd0, 32'h1008, 1'b0);
    send(FmtBeqz, 4'd0, 5'd0, 5'd1, 5'd2, 32'h184, 1'b0);
    drain(5);
    n_checks++;
    if (log_addr.size() != 3) begin
      n_fail++; $display("FAIL fmt_count: got %0d need 3", log_addr.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        n_checks++;
        if (log_addr[i] !== 8'(8'h17 + i) || log_data[i] !== exp[i]) begin
          n_fail++; $display("FAIL fmt_word%0d: got %h@%h need %h@%h", i, log_data[i], log_addr[i],
                             exp[i], 8'(8'h17 + i));
        end
      end
    end
  endtask

  task automatic test_reject();
    clear_log();
    send(4'hC, 4'd0, 5'd1, 5'd1, 5'd1, 32'h0, 1'b0);
    drain(4);
    n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL rej_err: got %b need 1", err); end
    n_checks++; if (err_cnt !== 8'd1) begin n_fail++; $display("FAIL rej_cnt: got %0d need 1", err_cnt); end
    n_checks++; if (log_addr.size() != 0) begin n_fail++; $display("FAIL rej_nowrite: got %0d need 0", log_addr.size()); end
    n_checks++; if (mem_addr !== 8'h1A) begin n_fail++; $display("FAIL rej_addr: got %h need 1a", mem_addr); end
    send(FmtLw, 4'd0, 5'd4, 5'd6, 5'd0, 32'hFFFF_FFFC, 1'b0);
    drain(4);
    n_checks++;
    if (log_addr.size() != 1 || log_addr[0] !== 8'h1A || log_data[0] !== 32'h7FFF_00C4) begin
      n_fail++; $display("FAIL rej_next_write: %0d writes, first %h@%h need 7fff00c4@1a",
                         log_addr.size(), log_data[0], log_addr[0]);
    end
`ifdef INSTR_ENCODER_RANGE_CHECK_EN
    clear_log();
    send(FmtBeqz, 4'd0, 5'd0, 5'd1, 5'd2, 32'd6, 1'b0);
    send(FmtI, 4'd0, 5'd1, 5'd1, 5'd0, 32'h2000, 1'b0);
    send(FmtR, 4'hF, 5'd1, 5'd1, 5'd1, 32'h0, 1'b0);
    drain(4);
    n_checks++; if (err_cnt !== 8'd4) begin n_fail++; $display("FAIL range_cnt: got %0d need 4", err_cnt); end
    n_checks++; if (log_addr.size() != 0) begin n_fail++; $display("FAIL range_nowrite: got %0d need 0", log_addr.size()); end
    n_checks++; if (mem_addr !== 8'h1B) begin n_fail++; $display("FAIL range_addr: got %h need 1b", mem_addr); end
`endif
  endtask

  task automatic test_halt();
    int n_done = 0;
    clear_log();
    send(FmtHalt, 4'd0, 5'd0, 5'd0, 5'd0, 32'h0, 1'b0);
    #1;
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL halt_in_ready: got %b need 0", in_ready); end
    repeat (8) begin
      @(posedge clk); #1;
      if (done) n_done++;
    end
    n_checks++; if (n_done != 1) begin n_fail++; $display("FAIL halt_done_pulses: got %0d need 1", n_done); end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL halt_busy_done: got %b need 1", busy); end
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL halt_done_ready: got %b need 0", in_ready); end
    n_checks++;
    if (log_addr.size() != 1 || log_addr[0] !== 8'h1B || log_data[0] !== 32'hE000_0000) begin
      n_fail++; $display("FAIL halt_word: %0d writes, first %h@%h need e0000000@1b",
                         log_addr.size(), log_data[0], log_addr[0]);
    end
    do_start(8'h40);
    n_checks++; if (mem_addr !== 8'h40) begin n_fail++; $display("FAIL restart_addr: got %h need 40", mem_addr); end
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL restart_err: got %b need 0", err); end
    n_checks++; if (err_cnt !== 8'd0) begin n_fail++; $display("FAIL restart_cnt: got %0d need 0", err_cnt); end
    clear_log();
    send(FmtR, 4'd2, 5'd1, 5'd5, 5'd7, 32'h0, 1'b1);
    drain(4);
    n_checks++;
    if (log_addr.size() != 1 || log_addr[0] !== 8'h40 || log_data[0] !== 32'h1001_C8A1) begin
      n_fail++; $display("FAIL restart_write: %0d writes, first %h@%h need 1001c8a1@40",
                         log_addr.size(), log_data[0], log_addr[0]);
    end
  endtask

  task automatic test_reset_mid();
    int n = 0;
    send(4'hD, 4'd0, 5'd0, 5'd0, 5'd0, 32'h0, 1'b0);
    drain(3);
    mem_ready = 1'b0;
    send(FmtR, 4'd1, 5'd2, 5'd3, 5'd4, 32'h0, 1'b0);
    while (!mem_we && n < 10) begin
      @(posedge clk); #1; n++;
    end
    n_checks++; if (mem_we !== 1'b1) begin n_fail++; $display("FAIL mid_we_pending: got %b need 1", mem_we); end
    #2;
    reset = 1'b0;
    #1;
    n_checks++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL mid_we: got %b need 0", mem_we); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mid_busy: got %b need 0", busy); end
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL mid_in_ready: got %b need 0", in_ready); end
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL mid_err: got %b need 0", err); end
    n_checks++; if (err_cnt !== 8'd0) begin n_fail++; $display("FAIL mid_cnt: got %0d need 0", err_cnt); end
    n_checks++; if (mem_addr !== 8'h00) begin n_fail++; $display("FAIL mid_addr: got %h need 00", mem_addr); end
    n_checks++; if (mem_wdata !== 32'h0) begin n_fail++; $display("FAIL mid_wdata: got %h need 0", mem_wdata); end
    mem_ready = 1'b1;
    clear_log();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    drain(4);
    n_checks++; if (log_addr.size() != 0) begin n_fail++; $display("FAIL mid_nowrite: got %0d need 0", log_addr.size()); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mid_idle: got %b need 0", busy); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_start();
    test_single_i();
    test_back_to_back();
    test_stall();
    test_formats();
    test_reject();
    test_halt();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
